operand_read_stage: RTL and testbench
=====================================

Name: operand_read_stage

Overview:
- Decode-to-execute boundary of the pipelined processor; consumes the two read ports of the 2R/1W register file.
- Drives register read numbers, resolves operands with EX/WB bypassing, detects load-use hazards and holds the ID/EX pipeline register.
- Emits a stall request upstream to fetch/decode.

Parameters:
DATA_WIDTH, 32, operand and result width
REG_NUM_WIDTH, 3, register number width (8 architectural registers, r0 hard-wired to 0)
CTRL_WIDTH, 8, opaque decoded control bundle carried to EX unchanged

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode slot holds a real instruction
id_rs_a, id_rs_b  in  REG_NUM_WIDTH  source register numbers
id_use_a, id_use_b  in  1  source actually read by the instruction
id_wr_num  in  REG_NUM_WIDTH  destination register
id_wr_en  in  1  instruction writes a register
id_is_load  in  1  instruction is a load
id_ctrl  in  CTRL_WIDTH  decoded control bundle
id_stall  out  1  hold fetch/decode this cycle (combinational)
rf_rd_num_a, rf_rd_num_b  out  REG_NUM_WIDTH  register-file read numbers (combinational = id_rs_a/b)
rf_rd_data_a, rf_rd_data_b  in  DATA_WIDTH  register-file read data (same cycle)
exr_valid, exr_wr_en  in  1  EX-stage result valid / writes register
exr_wr_num  in  REG_NUM_WIDTH  EX-stage destination
exr_data  in  DATA_WIDTH  EX-stage ALU result
wb_wr_en  in  1  writeback write enable (same signal as register file wrEnable)
wb_wr_num  in  REG_NUM_WIDTH  writeback destination
wb_data  in  DATA_WIDTH  writeback data
flush  in  1  kill instruction entering EX (branch redirect)
ex_stall  in  1  downstream EX cannot accept
ex_valid, ex_wr_en, ex_is_load  out  1  registered ID/EX fields
ex_op_a, ex_op_b  out  DATA_WIDTH  registered resolved operands
ex_wr_num  out  REG_NUM_WIDTH  registered destination
ex_ctrl  out  CTRL_WIDTH  registered control

Behaviour:
- Reset: all ex_* outputs 0; ex_valid 0; perf counter 0. Async assert, sync-safe deassert.
- Operand select per source, priority: register number 0 -> 0; EX hit (exr_valid & exr_wr_en & exr_wr_num==rs) -> exr_data; WB hit (wb_wr_en & wb_wr_num==rs) -> wb_data; else rf_rd_data. Unused source (id_use_x=0) -> 0.
- Load-use hazard: hz = id_valid & ex_valid & ex_is_load & ex_wr_en & ex_wr_num!=0 & ((id_use_a & id_rs_a==ex_wr_num) | (id_use_b & id_rs_b==ex_wr_num)).
- id_stall = (ex_stall | hz) & ~flush.
- Next-state priority per edge: flush -> ex_valid<=0, other fields don't care; else ex_stall -> hold all ex_* registers; else hz -> bubble (ex_valid<=0, ex_wr_en<=0, ex_is_load<=0); else load all fields from ID, ex_valid<=id_valid.
- Latency: 1 cycle ID->EX; load-use costs exactly 1 bubble cycle (resolved via WB bypass next cycle).
- Bubble/invalid entries always carry ex_wr_en=0.
- Reset mid-stall: pipeline register cleared, id_stall follows inputs immediately after release.
- Simultaneous EX and WB hit on same register: EX data wins (younger).

Optional Feature:
- Macro OPERAND_READ_PERF_EN.
- Defined: extra output perf_stall_cnt (32 bits), +1 each cycle hz=1 & ~flush & ~ex_stall, saturates at all-ones, reset 0.
- Undefined: port and counter absent; functional behaviour identical.

Decomposition:
- Shared package: DATA_WIDTH, REG_NUM_WIDTH, REG_FILE_SIZE, CTRL_WIDTH constants; DataPath, RegNumPath, CtrlPath types; ID/EX bundle struct.
- One sub-module: bypass_mux (rs, use, rf data, EX/WB forward inputs -> operand), instantiated twice.

Test Plan:
- Plain read: r3=0x11, r4=0x22 in file, id rs_a=3, rs_b=4, no hits -> next cycle ex_op_a=0x11, ex_op_b=0x22, ex_valid=1.
- Priority: exr writes r2=0xAAAA, wb writes r2=0x5555, id rs_a=2 -> ex_op_a=0xAAAA; rs_a=0 with exr_wr_num=0 -> ex_op_a=0.
- Load-use: load to r5 in EX, next id reads r5 -> id_stall=1 one cycle, ex_valid=0 bubble, then wb_data=0x1234 for r5 -> ex_op_a=0x1234.
- ex_stall held 3 cycles -> ex_* unchanged, id_stall=1 each cycle; released -> new instruction loaded.
- Flush during hazard and ex_stall -> id_stall=0, ex_valid=0 next cycle.
- Async reset asserted mid-cycle with ex_valid=1 -> ex_valid=0 immediately; with OPERAND_READ_PERF_EN, 4 load-use stalls -> perf_stall_cnt=4.

Source files
------------

// File: rtl/operand_read_stage_pkg.sv
// Shared constants and types for the operand read stage.
//   DATA_WIDTH    operand / result width
//   REG_NUM_WIDTH register number width (r0 reads as zero)
//   REG_FILE_SIZE number of architectural registers
//   CTRL_WIDTH    opaque decoded control bundle width
//   NUM_SRC       source operands per instruction (one bypass lane each)
package operand_read_stage_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int REG_NUM_WIDTH = 3;
    localparam int REG_FILE_SIZE = 1 << REG_NUM_WIDTH;
    localparam int CTRL_WIDTH    = 8;
    localparam int NUM_SRC       = 2;

    typedef logic [DATA_WIDTH-1:0]    DataPath;
    typedef logic [REG_NUM_WIDTH-1:0] RegNumPath;
    typedef logic [CTRL_WIDTH-1:0]    CtrlPath;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic      valid;
        logic      wrEn;
        logic      isLoad;
        RegNumPath wrNum;
        DataPath   opA;
        DataPath   opB;
        CtrlPath   ctrl;
    } IdExBundle;

endpackage

// File: rtl/operand_read_stage_bypass_mux.sv
// bypass_mux: resolves one source operand.
// Priority: unused source or r0 -> 0, EX result hit, WB hit, register file.
// Ports:
//   rs, useSrc                  source register number / source is read
//   rfData                      register-file read data
//   exrValid/exrWrEn/exrWrNum/exrData  EX-stage forward
//   wbWrEn/wbWrNum/wbData       writeback forward
//   operand                     resolved operand
module bypass_mux
    import operand_read_stage_pkg::*;
(
    input  RegNumPath rs,
    input  logic      useSrc,
    input  DataPath   rfData,
    input  logic      exrValid,
    input  logic      exrWrEn,
    input  RegNumPath exrWrNum,
    input  DataPath   exrData,
    input  logic      wbWrEn,
    input  RegNumPath wbWrNum,
    input  DataPath   wbData,
    output DataPath   operand
);

    // EX is checked before WB: it holds the younger value for the same register.
    always_comb begin
        operand = rfData;
        if (!useSrc || rs == '0)
            operand = '0;
        else if (exrValid && exrWrEn && exrWrNum == rs)
            operand = exrData;
        else if (wbWrEn && wbWrNum == rs)
            operand = wbData;
    end

endmodule

// File: rtl/operand_read_stage.sv
// operand_read_stage: decode-to-execute boundary.
// Drives register-file read numbers, bypasses EX/WB results into the operands,
// detects load-use hazards and holds the ID/EX pipeline register.
// Optional feature macro: OPERAND_READ_PERF_EN adds perf_stall_cnt, a saturating
// count of cycles lost to load-use bubbles.
// Ports:
//   clk, rst                      clock, async active-high reset
//   id_*                          decoded instruction in ID
//   id_stall                      hold fetch/decode (combinational)
//   rf_rd_num_a/b, rf_rd_data_a/b register-file read ports
//   exr_*                         EX-stage result forward
//   wb_*                          writeback forward
//   flush, ex_stall               kill entry into EX / EX back-pressure
//   ex_*                          registered ID/EX outputs
//   perf_stall_cnt                load-use stall cycles (macro only)
module operand_read_stage
    import operand_read_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      id_valid,
    input  RegNumPath id_rs_a,
    input  RegNumPath id_rs_b,
    input  logic      id_use_a,
    input  logic      id_use_b,
    input  RegNumPath id_wr_num,
    input  logic      id_wr_en,
    input  logic      id_is_load,
    input  CtrlPath   id_ctrl,
    output logic      id_stall,
    output RegNumPath rf_rd_num_a,
    output RegNumPath rf_rd_num_b,
    input  DataPath   rf_rd_data_a,
    input  DataPath   rf_rd_data_b,
    input  logic      exr_valid,
    input  logic      exr_wr_en,
    input  RegNumPath exr_wr_num,
    input  DataPath   exr_data,
    input  logic      wb_wr_en,
    input  RegNumPath wb_wr_num,
    input  DataPath   wb_data,
    input  logic      flush,
    input  logic      ex_stall,
    output logic      ex_valid,
    output logic      ex_wr_en,
    output logic      ex_is_load,
    output DataPath   ex_op_a,
    output DataPath   ex_op_b,
    output RegNumPath ex_wr_num,
    output CtrlPath   ex_ctrl
`ifdef OPERAND_READ_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    IdExBundle exq;
    IdExBundle idNext;

    RegNumPath [NUM_SRC-1:0] srcNum;
    logic      [NUM_SRC-1:0] srcUse;
    DataPath   [NUM_SRC-1:0] srcRf;
    DataPath   [NUM_SRC-1:0] srcOp;
    logic      [NUM_SRC-1:0] srcDep;
    logic                    hz;

    assign rf_rd_num_a = id_rs_a;
    assign rf_rd_num_b = id_rs_b;

    assign srcNum = {id_rs_b, id_rs_a};
    assign srcUse = {id_use_b, id_use_a};
    assign srcRf  = {rf_rd_data_b, rf_rd_data_a};

    for (genvar s = 0; s < NUM_SRC; s++) begin : gSrc
        bypass_mux uMux (
            .rs       (srcNum[s]),
            .useSrc   (srcUse[s]),
            .rfData   (srcRf[s]),
            .exrValid (exr_valid),
            .exrWrEn  (exr_wr_en),
            .exrWrNum (exr_wr_num),
            .exrData  (exr_data),
            .wbWrEn   (wb_wr_en),
            .wbWrNum  (wb_wr_num),
            .wbData   (wb_data),
            .operand  (srcOp[s])
        );
        assign srcDep[s] = srcUse[s] && (srcNum[s] == exq.wrNum);
    end

    // A load in EX has no data yet; a dependent instruction waits one cycle and
    // then picks the value up from the WB bypass.
    assign hz = id_valid && exq.valid && exq.isLoad && exq.wrEn &&
                (exq.wrNum != '0) && (|srcDep);

    assign id_stall = (ex_stall || hz) && !flush;

    // Side-effect flags are qualified by valid so invalid entries never write.
    always_comb begin
        idNext        = '0;
        idNext.valid  = id_valid;
        idNext.wrEn   = id_valid && id_wr_en;
        idNext.isLoad = id_valid && id_is_load;
        idNext.wrNum  = id_wr_num;
        idNext.opA    = srcOp[0];
        idNext.opB    = srcOp[1];
        idNext.ctrl   = id_ctrl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exq <= '0;
        end else if (flush) begin
            exq.valid  <= 1'b0;
            exq.wrEn   <= 1'b0;
            exq.isLoad <= 1'b0;
        end else if (!ex_stall) begin
            if (hz) begin
                exq.valid  <= 1'b0;
                exq.wrEn   <= 1'b0;
                exq.isLoad <= 1'b0;
            end else begin
                exq <= idNext;
            end
        end
    end

    assign ex_valid   = exq.valid;
    assign ex_wr_en   = exq.wrEn;
    assign ex_is_load = exq.isLoad;
    assign ex_op_a    = exq.opA;
    assign ex_op_b    = exq.opB;
    assign ex_wr_num  = exq.wrNum;
    assign ex_ctrl    = exq.ctrl;

`ifdef OPERAND_READ_PERF_EN
    logic [31:0] perfCnt;

    // Counts only cycles where a bubble is actually inserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perfCnt <= '0;
        else if (hz && !flush && !ex_stall && !(&perfCnt))
            perfCnt <= perfCnt + 32'd1;
    end

    assign perf_stall_cnt = perfCnt;
`endif

endmodule

// File: tb/tb_operand_read_stage.sv
// Directed self-checking bench for operand_read_stage.
module tb_operand_read_stage;
    import operand_read_stage_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      id_valid, id_use_a, id_use_b, id_wr_en, id_is_load;
    RegNumPath id_rs_a, id_rs_b, id_wr_num;
    CtrlPath   id_ctrl;
    logic      id_stall;
    RegNumPath rf_rd_num_a, rf_rd_num_b;
    DataPath   rf_rd_data_a, rf_rd_data_b;
    logic      exr_valid, exr_wr_en;
    RegNumPath exr_wr_num;
    DataPath   exr_data;
    logic      wb_wr_en;
    RegNumPath wb_wr_num;
    DataPath   wb_data;
    logic      flush, ex_stall;
    logic      ex_valid, ex_wr_en, ex_is_load;
    DataPath   ex_op_a, ex_op_b;
    RegNumPath ex_wr_num;
    CtrlPath   ex_ctrl;
`ifdef OPERAND_READ_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    DataPath rf [REG_FILE_SIZE];
    assign rf_rd_data_a = rf[rf_rd_num_a];
    assign rf_rd_data_b = rf[rf_rd_num_b];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_read_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_wr_num(id_wr_num),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_ctrl(id_ctrl),
        .id_stall(id_stall),
        .rf_rd_num_a(rf_rd_num_a), .rf_rd_num_b(rf_rd_num_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .exr_valid(exr_valid), .exr_wr_en(exr_wr_en),
        .exr_wr_num(exr_wr_num), .exr_data(exr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_num(wb_wr_num), .wb_data(wb_data),
        .flush(flush), .ex_stall(ex_stall),
        .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_wr_num(ex_wr_num),
        .ex_ctrl(ex_ctrl)
`ifdef OPERAND_READ_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs_a = 0; id_rs_b = 0; id_use_a = 0; id_use_b = 0;
        id_wr_num = 0; id_wr_en = 0; id_is_load = 0; id_ctrl = 0;
        exr_valid = 0; exr_wr_en = 0; exr_wr_num = 0; exr_data = 0;
        wb_wr_en = 0; wb_wr_num = 0; wb_data = 0;
        flush = 0; ex_stall = 0;
    endtask

    task automatic issue(input RegNumPath ra, input RegNumPath rb, input logic ua,
                         input logic ub, input RegNumPath wn, input logic we,
                         input logic ld, input CtrlPath c);
        id_valid = 1; id_rs_a = ra; id_rs_b = rb; id_use_a = ua; id_use_b = ub;
        id_wr_num = wn; id_wr_en = we; id_is_load = ld; id_ctrl = c;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < REG_FILE_SIZE; i++) rf[i] = 32'h100 * i;
        rf[2] = 32'h99; rf[3] = 32'h11; rf[4] = 32'h22; rf[5] = 32'h77;
        idle();
        rst = 1;
        #12;
        check("reset ex_valid", ex_valid, 0);
        check("reset ex_wr_en", ex_wr_en, 0);
        check("reset ex_op_a", ex_op_a, 0);
        check("reset ex_ctrl", ex_ctrl, 0);
        rst = 0;
        tick();

        // Plain read from the register file
        issue(3, 4, 1, 1, 1, 1, 0, 8'h5A);
        #3;
        check("rf_rd_num_a", rf_rd_num_a, 3);
        check("rf_rd_num_b", rf_rd_num_b, 4);
        check("plain id_stall", id_stall, 0);
        tick();
        check("plain ex_valid", ex_valid, 1);
        check("plain op_a", ex_op_a, 32'h11);
        check("plain op_b", ex_op_b, 32'h22);
        check("plain wr_num", ex_wr_num, 1);
        check("plain wr_en", ex_wr_en, 1);
        check("plain ctrl", ex_ctrl, 8'h5A);

        // Bypass priority: EX over WB, WB over file, unused source -> 0
        issue(2, 2, 1, 0, 6, 1, 0, 8'h01);
        exr_valid = 1; exr_wr_en = 1; exr_wr_num = 2; exr_data = 32'hAAAA;
        wb_wr_en = 1; wb_wr_num = 2; wb_data = 32'h5555;
        tick();
        check("ex beats wb", ex_op_a, 32'hAAAA);
        check("unused src b", ex_op_b, 0);
        exr_valid = 0;
        tick();
        check("wb hit", ex_op_a, 32'h5555);
        exr_valid = 1; exr_wr_en = 0;
        tick();
        check("exr_wr_en gates", ex_op_a, 32'h5555);
        issue(0, 2, 1, 1, 6, 1, 0, 8'h02);
        exr_wr_en = 1; exr_wr_num = 0; wb_wr_en = 0;
        tick();
        check("r0 forced zero", ex_op_a, 0);
        check("exr miss b from rf", ex_op_b, 32'h99);
        idle();

        // Load-use: one bubble, then WB bypass supplies the load value
        issue(1, 1, 0, 0, 5, 1, 1, 8'h10);
        tick();
        check("load in ex", ex_is_load, 1);
        issue(5, 3, 1, 1, 6, 1, 0, 8'h20);
        #3;
        check("load-use id_stall", id_stall, 1);
        tick();
        check("bubble ex_valid", ex_valid, 0);
        check("bubble ex_wr_en", ex_wr_en, 0);
        check("bubble ex_is_load", ex_is_load, 0);
        wb_wr_en = 1; wb_wr_num = 5; wb_data = 32'h1234;
        #3;
        check("after bubble id_stall", id_stall, 0);
        tick();
        check("load-use ex_valid", ex_valid, 1);
        check("load-use op_a", ex_op_a, 32'h1234);
        check("load-use op_b", ex_op_b, 32'h11);
        idle();

        // Load to r0 and unused dependent sources never stall
        issue(0, 0, 0, 0, 0, 1, 1, 8'h00);
        tick();
        issue(0, 0, 1, 1, 1, 1, 0, 8'h00);
        #3;
        check("load r0 no stall", id_stall, 0);
        issue(1, 1, 0, 0, 5, 1, 1, 8'h00);
        tick();
        issue(5, 5, 0, 0, 1, 1, 0, 8'h00);
        #3;
        check("unused src no stall", id_stall, 0);
        idle();
        tick();

        // Three more load-use stalls on source b
        for (int k = 0; k < 3; k++) begin
            issue(1, 1, 0, 0, 5, 1, 1, 8'h00);
            tick();
            issue(0, 5, 0, 1, 2, 1, 0, 8'h00);
            #3;
            check("loop stall", id_stall, 1);
            tick();
            check("loop bubble", ex_valid, 0);
            idle();
            tick();
        end
`ifdef OPERAND_READ_PERF_EN
        check("perf count 4", perf_stall_cnt, 4);
`endif

        // ex_stall holds the register for 3 cycles
        issue(3, 4, 1, 1, 7, 1, 0, 8'hC3);
        tick();
        issue(4, 3, 1, 1, 2, 1, 0, 8'h3C);
        ex_stall = 1;
        for (int k = 0; k < 3; k++) begin
            #3;
            check("ex_stall id_stall", id_stall, 1);
            tick();
            check("hold ctrl", ex_ctrl, 8'hC3);
            check("hold op_a", ex_op_a, 32'h11);
            check("hold wr_num", ex_wr_num, 7);
        end
        ex_stall = 0;
        #3;
        check("release id_stall", id_stall, 0);
        tick();
        check("released ctrl", ex_ctrl, 8'h3C);
        check("released op_a", ex_op_a, 32'h22);
        idle();

        // Flush during hazard and ex_stall
        issue(1, 1, 0, 0, 5, 1, 1, 8'h00);
        tick();
        issue(5, 0, 1, 0, 3, 1, 0, 8'h00);
        ex_stall = 1; flush = 1;
        #3;
        check("flush id_stall", id_stall, 0);
        tick();
        check("flush ex_valid", ex_valid, 0);
        check("flush ex_wr_en", ex_wr_en, 0);
        idle();
`ifdef OPERAND_READ_PERF_EN
        check("perf no count on flush", perf_stall_cnt, 4);
`endif

        // Async reset mid-cycle, and id_stall follows inputs around it
        issue(3, 4, 1, 1, 1, 1, 0, 8'h77);
        tick();
        check("pre-reset ex_valid", ex_valid, 1);
        #2;
        rst = 1; ex_stall = 1;
        #1;
        check("async reset ex_valid", ex_valid, 0);
        check("async reset op_a", ex_op_a, 0);
        check("stall during reset", id_stall, 1);
`ifdef OPERAND_READ_PERF_EN
        check("reset perf", perf_stall_cnt, 0);
`endif
        #4;
        rst = 0; ex_stall = 0;
        #1;
        check("post-reset id_stall", id_stall, 0);
        tick();
        check("post-reset load", ex_ctrl, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
